// File: rtl/alu_req_scheduler.sv
// Two-requester scheduler for the shared 16-bit ALU: grant, hold operands for a settle window, return a tagged result.
// Define ALU_SCHED_RR_EN for round-robin arbitration; by default requester 0 has fixed priority.
module alu_req_scheduler #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_r,
  input  logic        alu_ovf,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_err,
  output logic [1:0]  err_sticky,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_MOD   = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_RESET = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd8;
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic        grant;
  logic        accept;
  logic        capture;
  logic [1:0]  err_now;

`ifdef ALU_SCHED_RR_EN
  logic ptr;

  // With both requesting, the pointer decides; otherwise the lone requester wins.
  always_comb begin
    grant = (req_valid == 2'b11) ? ptr : ~req_valid[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= ~grant;
    end
  end
`else
  always_comb begin
    grant = ~req_valid[0];
  end
`endif

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    req_ready  = 2'b00;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid != 2'b00) begin
          accept         = 1'b1;
          req_ready      = grant ? 2'b10 : 2'b01;
          state_next     = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    err_now    = 2'b00;
    err_now[1] = ((alu_op == OP_MOD) || (alu_op == OP_DIV)) && (alu_b == 16'd0);
    err_now[0] = ((alu_op == OP_ADD) || (alu_op == OP_SUB)) && alu_ovf;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 4'd0;
      alu_a      <= 16'd0;
      alu_b      <= 16'd0;
      alu_op     <= OP_RESET;
      rsp_id     <= 1'b0;
      rsp_data   <= 32'd0;
      rsp_err    <= 2'b00;
      err_sticky <= 2'b00;
    end else begin
      if (accept) begin
        cnt    <= CNT_LOAD;
        rsp_id <= grant;
        alu_a  <= grant ? req1_a  : req0_a;
        alu_b  <= grant ? req1_b  : req0_b;
        alu_op <= grant ? req1_op : req0_op;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (capture) begin
        // The reset op returns a clean zero response and wipes the sticky flags.
        if (alu_op == OP_RESET) begin
          rsp_data   <= 32'd0;
          rsp_err    <= 2'b00;
          err_sticky <= 2'b00;
        end else begin
          rsp_data   <= alu_r;
          rsp_err    <= err_now;
          err_sticky <= err_sticky | err_now;
        end
      end
    end
  end

  always_comb begin
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed bench for alu_req_scheduler with a small behavioural ALU standing in for the shared ALU.
// Expected arbitration order follows ALU_SCHED_RR_EN, matching the build of the design.
module tb_alu_req_scheduler;

  localparam int SETTLE = 4;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_r;
  logic        alu_ovf;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;
  logic [1:0]  err_sticky;
  logic        busy;

  int vectors;
  int miscompares;

  alu_req_scheduler #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_r      (alu_r),
    .alu_ovf    (alu_ovf),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .err_sticky (err_sticky),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU: 16-bit add/sub sign-extended to 32 bits, all-ones on divide by zero.
  logic [15:0] sum16;
  always_comb begin
    sum16   = 16'd0;
    alu_r   = 32'd0;
    alu_ovf = 1'b0;
    case (alu_op)
      4'd0: begin
        sum16   = alu_a + alu_b;
        alu_r   = {{16{sum16[15]}}, sum16};
        alu_ovf = (alu_a[15] == alu_b[15]) && (sum16[15] != alu_a[15]);
      end
      4'd8: begin
        sum16   = alu_a - alu_b;
        alu_r   = {{16{sum16[15]}}, sum16};
        alu_ovf = (alu_a[15] != alu_b[15]) && (sum16[15] != alu_a[15]);
      end
      4'd1: alu_r = (alu_b == 16'd0) ? 32'hFFFF_FFFF : {16'd0, alu_a % alu_b};
      4'd2: alu_r = (alu_b == 16'd0) ? 32'hFFFF_FFFF : {16'd0, alu_a / alu_b};
      4'd4: alu_r = {16'd0, alu_a} * {16'd0, alu_b};
      4'd5: alu_r = {16'd0, alu_a & alu_b};
      4'd6: alu_r = {16'd0, alu_a | alu_b};
      4'd7: alu_r = {16'd0, alu_a ^ alu_b};
      default: alu_r = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its response; checks grant, operand latch and latency.
  task automatic do_op(input string tag, input int id, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] op);
    int lat;
    @(negedge clk);
    if (id == 0) begin
      req0_a = a; req0_b = b; req0_op = op; req_valid = 2'b01;
    end else begin
      req1_a = a; req1_b = b; req1_op = op; req_valid = 2'b10;
    end
    #1;
    check({tag, "_ready"}, 32'(req_ready), (id == 0) ? 32'd1 : 32'd2);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    req0_a = 16'hDEAD; req1_a = 16'hBEEF;
    check({tag, "_alu_a"}, 32'(alu_a), 32'(a));
    check({tag, "_alu_op"}, 32'(alu_op), 32'(op));
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(SETTLE));
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] data, input logic id,
                           input logic [1:0] err, input logic [1:0] sticky);
    check({tag, "_data"}, rsp_data, data);
    check({tag, "_id"}, 32'(rsp_id), 32'(id));
    check({tag, "_err"}, 32'(rsp_err), 32'(err));
    check({tag, "_sticky"}, 32'(err_sticky), 32'(sticky));
  endtask

  task automatic release_rsp(input string tag);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, "_done"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] hold_data;
    logic [1:0]  ids [4];
    logic [31:0] datas [4];
    int          times [4];
    int          n, cyc;
    logic        seen;
    logic [1:0]  exp_id [4];

    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    req0_a = 16'd0; req0_b = 16'd0; req0_op = 4'd0;
    req1_a = 16'd0; req1_b = 16'd0; req1_op = 4'd0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd3);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp", rsp_data, 32'd0);
    check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_sticky", 32'(err_sticky), 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("add", 0, 16'd6, 16'd9, 4'd0);
    check_rsp("add", 32'd15, 1'b0, 2'b00, 2'b00);
    release_rsp("add");

    do_op("div0", 1, 16'd100, 16'd0, 4'd2);
    check_rsp("div0", 32'hFFFF_FFFF, 1'b1, 2'b10, 2'b10);
    release_rsp("div0");

    do_op("clr", 1, 16'd0, 16'd0, 4'd3);
    check_rsp("clr", 32'd0, 1'b1, 2'b00, 2'b00);
    release_rsp("clr");

    do_op("ovf", 0, 16'h7FFF, 16'd1, 4'd0);
    check_rsp("ovf", 32'hFFFF_8000, 1'b0, 2'b01, 2'b01);
    release_rsp("ovf");

    do_op("and", 0, 16'h7FFF, 16'd1, 4'd5);
    check_rsp("and", 32'd1, 1'b0, 2'b00, 2'b01);
    release_rsp("and");
    check("idle_hold_alu_a", 32'(alu_a), 32'h7FFF);
    check("idle_hold_alu_op", 32'(alu_op), 32'd5);

    // Backpressure: response must hold while both requesters wait.
    do_op("mul", 1, 16'd3, 16'd4, 4'd4);
    check_rsp("mul", 32'd12, 1'b1, 2'b00, 2'b01);
    @(negedge clk);
    req0_a = 16'd1; req0_b = 16'd2; req0_op = 4'd0;
    req1_a = 16'd10; req1_b = 16'd3; req1_op = 4'd8;
    req_valid = 2'b11;
    hold_data = rsp_data;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_data", rsp_data, 32'd12);
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_busy", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    check("bp_done", {31'd0, rsp_valid}, 32'd0);

    // Arbitration with both requesters held and responses drained immediately.
`ifdef ALU_SCHED_RR_EN
    exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd0; exp_id[3] = 2'd1;
`else
    exp_id[0] = 2'd0; exp_id[1] = 2'd0; exp_id[2] = 2'd0; exp_id[3] = 2'd0;
`endif
    @(negedge clk);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (rsp_valid) begin
        ids[n] = {1'b0, rsp_id};
        datas[n] = rsp_data;
        times[n] = cyc;
        n++;
      end
    end
    req_valid = 2'b00;
    check("arb_count", 32'(n), 32'd4);
    for (int i = 0; i < n; i++) begin
      check("arb_id", 32'(ids[i]), 32'(exp_id[i]));
      check("arb_data", datas[i], (exp_id[i] == 2'd0) ? 32'd3 : 32'd7);
      if (i > 0) check("arb_period", 32'(times[i] - times[i-1]), 32'(SETTLE + 2));
    end
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset in the middle of the settle window discards the operation.
    @(negedge clk);
    req0_a = 16'd2; req0_b = 16'd2; req0_op = 4'd6;
    req_valid = 2'b01;
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_alu_a", 32'(alu_a), 32'd0);
    check("mid_rst_alu_op", 32'(alu_op), 32'd3);
    check("mid_rst_sticky", 32'(err_sticky), 32'd0);
    check("mid_rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid || busy) seen = 1'b1;
    end
    check("post_rst_quiet", {31'd0, seen}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
